// File: rtl/os_input_buf.sv
// Oversampled polyphase input buffer: stores the sample stream in a RAM and
// replays overlapping M-sample windows (hop D), newest sample first.
module os_input_buf #(
    parameter int M     = 8,
    parameter int D     = 6,
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             dout_last
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int JW = (M > 1) ? $clog2(M) : 1;

    localparam logic [CW-1:0] M_C     = CW'(M);
    localparam logic [CW-1:0] D_C     = CW'(D);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [JW-1:0] J_TOP   = JW'(M - 1);
    localparam logic [JW-1:0] J_ONE   = JW'(1);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]    base_q, base_d;
    logic [JW-1:0]    j_q, j_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_last_q, dout_last_d;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    occ;
    logic [CW-1:0]    occ_after;
    logic             accept;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;

    // Counters carry one extra bit so full and empty stay distinguishable.
    assign occ       = wr_cnt_q - base_q;
    assign occ_after = wr_cnt_q - base_q - D_C;
    assign din_ready = rst_n & (occ < DEPTH_C);
    assign accept    = din_valid & din_ready;
    assign rd_addr   = base_q[AW-1:0] + AW'(j_q);

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        base_d       = base_q;
        j_d          = j_q;
        rd_en        = 1'b0;
        if (accept) begin
            wr_cnt_d = wr_cnt_q + ONE_C;
        end
        unique case (state_q)
            IDLE: begin
                if (occ >= M_C) begin
                    state_d = EMIT;
                    j_d     = J_TOP;
                end
            end
            EMIT: begin
                rd_en = 1'b1;
                if (j_q == '0) begin
                    base_d = base_q + D_C;
                    j_d    = J_TOP;
                    if (occ_after < M_C) begin
                        state_d = IDLE;
                    end
                end else begin
                    j_d = j_q - J_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        dout_d       = rd_en ? mem[rd_addr] : dout_q;
        dout_valid_d = rd_en;
        dout_last_d  = rd_en & (j_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_cnt_q     <= '0;
            base_q       <= '0;
            j_q          <= J_TOP;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            base_q       <= base_d;
            j_q          <= j_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
        end
    end

    // Sample storage needs no reset; stale words are never read.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_cnt_q[AW-1:0]] <= din;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;

endmodule

// File: doc/os_input_buf.md
OS_INPUT_BUF -- requirements
Module: os_input_buf

Interface
REQ-001 SHALL have parameter M, 8, polyphase branch count (output frame length).
REQ-002 SHALL have parameter D, 6, decimation (new samples per frame); 1 <= D <= M.
REQ-003 SHALL have parameter WIDTH, 16, sample width in bits.
REQ-004 SHALL have parameter DEPTH, 16, sample RAM depth; power of two, DEPTH >= M+D.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port din  input  WIDTH  input sample x[n].
REQ-008 SHALL have port din_valid  input  1  din holds a valid sample.
REQ-009 SHALL have port din_ready  output  1  block accepts din this cycle.
REQ-010 SHALL have port dout  output  WIDTH  output sample to polyphase FIR / phase compensation path.
REQ-011 SHALL have port dout_valid  output  1  dout valid; no backpressure, downstream consumes every valid cycle.
REQ-012 SHALL have port dout_last  output  1  marks final sample of a frame.

Function
REQ-013 SHALL accept a sample on every clk edge where din_valid && din_ready, writing it to RAM at address wr_cnt mod DEPTH and incrementing wr_cnt.
REQ-014 SHALL keep wr_cnt and base counters $clog2(DEPTH)+1 bits wide, wrapping modulo 2*DEPTH; occupancy = (wr_cnt - base) mod 2*DEPTH.
REQ-015 SHALL drive din_ready = (occupancy < DEPTH) from registered counters, forced 0 while rst_n low.
REQ-016 SHALL produce frame k as samples x[kD+M-1], x[kD+M-2], ..., x[kD], newest first (overlapping windows, hop D).
REQ-017 SHALL implement FSM states IDLE and EMIT, plus a branch index j counting M-1 down to 0.
REQ-018 IDLE: SHALL move to EMIT with j=M-1 on the next edge when occupancy >= M; otherwise remain IDLE.
REQ-019 EMIT: SHALL issue one RAM read per cycle at address (base+j) mod DEPTH, decrementing j.
REQ-020 SHALL register dout and dout_valid one cycle after each read (read latency 1); dout_last SHALL assert with the j=0 sample.
REQ-021 On the j=0 EMIT cycle: SHALL advance base by D; SHALL stay in EMIT with j=M-1 if (wr_cnt - base - D) mod 2*DEPTH >= M, else go to IDLE; back-to-back frames leave no dout_valid gap.
REQ-022 Simultaneous write and base advance SHALL both take effect on the same edge; freed space is visible on din_ready the following cycle.
REQ-023 SHALL never read an address whose sample arrives in the same cycle: frames start only on registered occupancy.
REQ-024 SHALL, under continuous din_valid, sustain D accepted inputs per M output cycles with dout_valid continuously high after the first frame.
REQ-025 dout SHALL hold its last value when dout_valid is 0.

Reset
REQ-026 While rst_n low: wr_cnt=0, base=0, j=M-1, state=IDLE, dout=0, dout_valid=0, dout_last=0, din_ready=0, asserted asynchronously.
REQ-027 Reset mid-frame SHALL discard all stored samples and any partial frame; no dout_valid until M new samples are accepted after release.
REQ-028 RAM contents SHALL NOT require reset.

Verification (M=8, D=6, DEPTH=16, WIDTH=16)
REQ-029 Reset release, din=n with din_valid=1 continuously -> frame0 = 7..0, frame1 = 13..6, frame2 = 19..12; dout_last on 0, 6, 12.
REQ-030 Continuous input for 40 frames -> dout_valid high with no gaps after frame0 start; exactly 6 samples accepted per 8 output cycles in steady state; din_ready drops when occupancy reaches 16.
REQ-031 din_valid one cycle in three -> first dout_valid exactly 2 cycles after the edge accepting sample 7; frames separated by IDLE gaps; contents as REQ-029.
REQ-032 rst_n pulsed low during EMIT at j=3 -> outputs 0 immediately; after release with din restarting at 100, first frame = 107..100.
REQ-033 Run 200 frames continuous -> frame k first sample = 6k+7 and last = 6k across counter wrap at 32; no dropped or duplicated samples.
REQ-034 Parameter set M=4, D=3, DEPTH=8 -> frame k = 3k+3 .. 3k with same protocol checks.
